button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_pkg.sv | 25 ++
 rtl/button_conditioner_debounce_channel.sv | 122 ++++++++++++
 rtl/button_conditioner.sv | 75 +++++++
 tb/tb_button_conditioner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared constants for the four-key button conditioner: default timing,
// key bit positions and the auto-repeat phase encoding.
package button_conditioner_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;   // 20 ms at 50 MHz
  localparam int DEFAULT_REPEAT_DELAY    = 25000000;  // 0.5 s
  localparam int DEFAULT_REPEAT_PERIOD   = 5000000;   // 0.1 s

  localparam int NUM_KEYS     = 4;
  localparam int KEY_LEFT     = 0;
  localparam int KEY_RIGHT    = 1;
  localparam int KEY_RESERVED = 2;
  localparam int KEY_FIRE     = 3;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_PERIOD = 2'd2
  } rpt_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One key: 2-flop synchronizer, stability-counter debounce, press/release
// edge pulses and a hold-to-repeat generator. All outputs are flops.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  rpt_state_e       rpt_state_q, rpt_state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      level_q     <= 1'b1;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeat_q    <= 1'b0;
      db_cnt_q    <= '0;
      rpt_cnt_q   <= '0;
      rpt_state_q <= RPT_IDLE;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
      db_cnt_q    <= db_cnt_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_state_q <= rpt_state_d;
    end
  end

  // Debounce: the counter only runs while the synchronized sample disagrees
  // with the accepted level; any agreeing cycle restarts the stability window.
  always_comb begin
    sync1_d   = raw_i;
    sync2_d   = sync1_q;
    level_d   = level_q;
    db_cnt_d  = db_cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d   = sync2_q;
      db_cnt_d  = '0;
      press_d   = ~sync2_q;
      release_d = sync2_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Repeat phase: a press (re)starts the initial delay; the repeat pulse is
  // gated by the next level so a release cycle can never carry one.
  always_comb begin
    rpt_state_d = rpt_state_q;
    rpt_cnt_d   = rpt_cnt_q;
    repeat_d    = 1'b0;
    if (press_d) begin
      rpt_state_d = RPT_DELAY;
      rpt_cnt_d   = '0;
    end else if (level_d) begin
      rpt_state_d = RPT_IDLE;
      rpt_cnt_d   = '0;
    end else begin
      case (rpt_state_q)
        RPT_DELAY: begin
          if (rpt_cnt_q == DELAY_LAST) begin
            repeat_d    = 1'b1;
            rpt_cnt_d   = '0;
            rpt_state_d = RPT_PERIOD;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
          end
        end
        RPT_PERIOD: begin
          if (rpt_cnt_q == PERIOD_LAST) begin
            repeat_d  = 1'b1;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
          end
        end
        default: rpt_cnt_d = '0;
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Four independent key conditioners (left, right, reserved, fire) producing
// debounced active-low levels plus press/release/auto-repeat pulses.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] btn_raw,
  output logic [NUM_KEYS-1:0] btn_level,
  output logic [NUM_KEYS-1:0] btn_press,
  output logic [NUM_KEYS-1:0] btn_release,
  output logic [NUM_KEYS-1:0] btn_repeat
);

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_left (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (btn_raw[KEY_LEFT]),
    .level_o  (btn_level[KEY_LEFT]),
    .press_o  (btn_press[KEY_LEFT]),
    .release_o(btn_release[KEY_LEFT]),
    .repeat_o (btn_repeat[KEY_LEFT])
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_right (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (btn_raw[KEY_RIGHT]),
    .level_o  (btn_level[KEY_RIGHT]),
    .press_o  (btn_press[KEY_RIGHT]),
    .release_o(btn_release[KEY_RIGHT]),
    .repeat_o (btn_repeat[KEY_RIGHT])
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_reserved (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (btn_raw[KEY_RESERVED]),
    .level_o  (btn_level[KEY_RESERVED]),
    .press_o  (btn_press[KEY_RESERVED]),
    .release_o(btn_release[KEY_RESERVED]),
    .repeat_o (btn_repeat[KEY_RESERVED])
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_fire (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (btn_raw[KEY_FIRE]),
    .level_o  (btn_level[KEY_FIRE]),
    .press_o  (btn_press[KEY_FIRE]),
    .release_o(btn_release[KEY_FIRE]),
    .repeat_o (btn_repeat[KEY_FIRE])
  );

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short timing constants: directed
// scenarios followed by randomized key activity against a reference model.
module tb_button_conditioner;

  localparam int DB = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic       clk;
  logic       reset;
  logic [3:0] btn_raw;
  logic [3:0] btn_level, btn_press, btn_release, btn_repeat;

  int errors = 0;
  int checks = 0;
  logic [3:0] seen = '0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a level is accepted once the input, seen two edges late,
  // has differed from the current level for DB consecutive samples. Repeats
  // fall at RD, RD+RP, RD+2RP ... cycles after the press pulse.
  logic [3:0] raw_h1 = '1, raw_h2 = '1;
  logic [3:0] m_level = '1, m_press = '0, m_release = '0, m_repeat = '0;
  int run_len [4] = '{default: 0};
  int held    [4] = '{default: 0};

  always @(posedge clk) begin
    if (reset) begin
      raw_h1 = '1; raw_h2 = '1;
      m_level = '1; m_press = '0; m_release = '0; m_repeat = '0;
      for (int i = 0; i < 4; i++) begin
        run_len[i] = 0;
        held[i]    = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        m_press[i] = 1'b0; m_release[i] = 1'b0; m_repeat[i] = 1'b0;
        if (raw_h2[i] == m_level[i]) run_len[i] = 0;
        else run_len[i] = run_len[i] + 1;
        if (run_len[i] == DB) begin
          run_len[i] = 0;
          m_level[i] = raw_h2[i];
          if (m_level[i] == 1'b0) begin
            m_press[i] = 1'b1;
            held[i]    = 0;
          end else begin
            m_release[i] = 1'b1;
          end
        end else if (m_level[i] == 1'b0) begin
          held[i] = held[i] + 1;
          if (held[i] >= RD && ((held[i] - RD) % RP) == 0) m_repeat[i] = 1'b1;
        end
      end
      raw_h2 = raw_h1;
      raw_h1 = btn_raw;
    end
  end

  // driver / checker tasks
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      seen = seen | btn_press | btn_release | btn_repeat;
      chk("model_level",   btn_level,   m_level);
      chk("model_press",   btn_press,   m_press);
      chk("model_release", btn_release, m_release);
      chk("model_repeat",  btn_repeat,  m_repeat);
    end
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 4'hF;
    #1;
    chk("reset_level",   btn_level,   4'hF);
    chk("reset_press",   btn_press,   4'h0);
    chk("reset_release", btn_release, 4'h0);
    chk("reset_repeat",  btn_repeat,  4'h0);
    steps(3);
    reset = 1'b0;

    // idle
    seen = '0;
    steps(50);
    chk("idle_level", btn_level, 4'hF);
    chk("idle_pulses", seen, 4'h0);

    // bit0 press: accepted on the 10th edge
    btn_raw = 4'b1110;
    steps(9);
    chk("b0_not_yet", btn_level, 4'hF);
    steps(1);
    chk("b0_level", btn_level, 4'b1110);
    chk("b0_press", btn_press, 4'b0001);
    steps(1);
    chk("b0_press_one_cycle", btn_press, 4'h0);
    btn_raw = 4'hF;
    steps(12);
    chk("b0_released", btn_level, 4'hF);

    // bit1 glitch of 5 cycles
    seen = '0;
    btn_raw = 4'b1101;
    steps(5);
    btn_raw = 4'hF;
    steps(15);
    chk("glitch_level", btn_level, 4'hF);
    chk("glitch_pulses", seen, 4'h0);

    // bit3 hold with auto-repeat
    btn_raw = 4'b0111;
    steps(10);
    chk("b3_press", btn_press, 4'b1000);
    for (int k = 1; k <= 39; k++) begin
      logic [3:0] exp_rep;
      steps(1);
      exp_rep = (k >= RD && ((k - RD) % RP) == 0) ? 4'b1000 : 4'b0000;
      chk($sformatf("b3_repeat_k%0d", k), btn_repeat, exp_rep);
    end
    btn_raw = 4'hF;
    steps(10);
    chk("b3_release", btn_release, 4'b1000);
    chk("b3_no_repeat_on_release", btn_repeat, 4'h0);
    chk("b3_level", btn_level, 4'hF);
    seen = '0;
    steps(30);
    chk("b3_quiet_after", seen, 4'h0);

    // simultaneous bit0/bit1
    btn_raw = 4'b1100;
    steps(9);
    chk("dual_not_yet", btn_press, 4'h0);
    steps(1);
    chk("dual_press", btn_press, 4'b0011);
    chk("dual_level", btn_level, 4'b1100);
    btn_raw = 4'hF;
    steps(12);

    // reset in the middle of a bit2 debounce, key held through it
    btn_raw = 4'b1011;
    steps(4);
    reset = 1'b1;
    #1;
    chk("midrst_level",   btn_level,   4'hF);
    chk("midrst_press",   btn_press,   4'h0);
    chk("midrst_release", btn_release, 4'h0);
    chk("midrst_repeat",  btn_repeat,  4'h0);
    steps(2);
    reset = 1'b0;
    steps(9);
    chk("b2_not_yet", btn_level, 4'hF);
    steps(1);
    chk("b2_level", btn_level, 4'b1011);
    chk("b2_press", btn_press, 4'b0100);
    btn_raw = 4'hF;
    steps(12);

    // randomized key activity, occasional reset
    for (int s = 0; s < 80; s++) begin
      btn_raw = 4'($urandom_range(0, 15));
      steps($urandom_range(1, 35));
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        steps(1);
        reset = 1'b0;
      end
    end
    btn_raw = 4'hF;
    steps(40);
    chk("final_level", btn_level, 4'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
